// File: rtl/text_writer.sv
// Character-stream writer: cursor tracking, control codes, and character RAM writes with
// rotating-row scroll. Optional backspace support is enabled by TEXT_WRITER_BACKSPACE_EN.
module text_writer #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [7:0]               in_ascii,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [7:0]               wr_data,
  output logic [$clog2(COLS)-1:0]  cur_col,
  output logic [$clog2(ROWS)-1:0]  cur_row,
  output logic [$clog2(ROWS)-1:0]  scroll_base
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [CW-1:0]     COL_MAX   = CW'(COLS - 1);
  localparam logic [RW-1:0]     ROW_MAX   = RW'(ROWS - 1);
  localparam logic [RW:0]       ROWS_E    = (RW+1)'(ROWS);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
  localparam logic [7:0]        BLANK     = 8'h20;

  typedef enum logic [1:0] {INIT, IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] clrb_q, clrb_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [RW-1:0]     base_q, base_d;
  logic              rdy_q, rdy_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;

  logic [RW:0]       row_sum;
  logic [RW-1:0]     phys_row;
  logic [RW-1:0]     base_next;
  logic [ADDR_W-1:0] cell_addr;
  logic              accept;

  // Logical-to-physical row mapping; the new bottom row after a scroll is the old base.
  always_comb begin
    row_sum   = {1'b0, row_q} + {1'b0, base_q};
    phys_row  = (row_sum >= ROWS_E) ? RW'(row_sum - ROWS_E) : RW'(row_sum);
    base_next = (base_q == ROW_MAX) ? '0 : base_q + RW'(1);
    cell_addr = ADDR_W'(phys_row) * COLS_A + ADDR_W'(col_q);
    accept    = in_valid && rdy_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clrb_d  = clrb_q;
    col_d   = col_q;
    row_d   = row_q;
    base_d  = base_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      INIT: begin
        wen_d   = 1'b1;
        waddr_d = cnt_q;
        wdata_d = BLANK;
        cnt_d   = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_CELL) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        if (accept) begin
          if (in_ascii >= 8'h20 && in_ascii <= 8'h7E) begin
            wen_d   = 1'b1;
            waddr_d = cell_addr;
            wdata_d = in_ascii;
            if (col_q < COL_MAX) begin
              col_d = col_q + CW'(1);
            end else begin
              col_d = '0;
              if (row_q < ROW_MAX) begin
                row_d = row_q + RW'(1);
              end else begin
                base_d  = base_next;
                clrb_d  = ADDR_W'(base_q) * COLS_A;
                cnt_d   = '0;
                state_d = CLEAR;
              end
            end
          end else if (in_ascii == 8'h0A) begin
            col_d = '0;
            if (row_q < ROW_MAX) begin
              row_d = row_q + RW'(1);
            end else begin
              // Nothing else to write this cycle, so the first clear write goes out now.
              base_d  = base_next;
              clrb_d  = ADDR_W'(base_q) * COLS_A;
              wen_d   = 1'b1;
              waddr_d = ADDR_W'(base_q) * COLS_A;
              wdata_d = BLANK;
              cnt_d   = ADDR_W'(1);
              state_d = CLEAR;
            end
          end else if (in_ascii == 8'h0D) begin
            col_d = '0;
          end
`ifdef TEXT_WRITER_BACKSPACE_EN
          else if (in_ascii == 8'h08 && col_q != '0) begin
            col_d   = col_q - CW'(1);
            wen_d   = 1'b1;
            waddr_d = cell_addr - ADDR_W'(1);
            wdata_d = BLANK;
          end
`endif
        end
      end
      CLEAR: begin
        wen_d   = 1'b1;
        waddr_d = clrb_q + cnt_q;
        wdata_d = BLANK;
        cnt_d   = cnt_q + ADDR_W'(1);
        if (cnt_q == COLS_A - ADDR_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = INIT;
    endcase
    // Ready only once IDLE has been held for a cycle, so it trails the last write.
    rdy_d = (state_q == IDLE) && (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= INIT;
      cnt_q   <= '0;
      clrb_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      base_q  <= '0;
      rdy_q   <= 1'b0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clrb_q  <= clrb_d;
      col_q   <= col_d;
      row_q   <= row_d;
      base_q  <= base_d;
      rdy_q   <= rdy_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign in_ready    = rdy_q;
  assign wr_en       = wen_q;
  assign wr_addr     = waddr_q;
  assign wr_data     = wdata_q;
  assign cur_col     = col_q;
  assign cur_row     = row_q;
  assign scroll_base = base_q;
endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer at COLS=4, ROWS=3; backspace expectations follow
// TEXT_WRITER_BACKSPACE_EN.
module tb_text_writer;
  localparam int COLS   = 4;
  localparam int ROWS   = 3;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              clr;
  logic [7:0]        in_ascii;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [1:0]        cur_col;
  logic [1:0]        cur_row;
  logic [1:0]        scroll_base;

  int errors = 0;
  int checks = 0;

  text_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .clr(clr), .in_ascii(in_ascii), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cur_col(cur_col), .cur_row(cur_row), .scroll_base(scroll_base)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_ascii = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_wr(input string tag, input logic [ADDR_W-1:0] a, input logic [7:0] d);
    chk({tag, ".en"}, wr_en, 1);
    chk({tag, ".addr"}, wr_addr, a);
    chk({tag, ".data"}, wr_data, d);
  endtask

  initial begin
    clr = 1'b1; in_valid = 1'b0; in_ascii = 8'h00;
    step(); step();
    chk("rst.ready", in_ready, 0);
    chk("rst.wr_en", wr_en, 0);
    chk("rst.addr", wr_addr, 0);
    chk("rst.data", wr_data, 0);
    chk("rst.col", cur_col, 0);
    chk("rst.row", cur_row, 0);
    chk("rst.base", scroll_base, 0);

    // Screen init: 12 blank writes, then ready
    clr = 1'b0;
    for (int i = 0; i < COLS * ROWS; i++) begin
      step();
      chk_wr("init", ADDR_W'(i), 8'h20);
      chk("init.ready", in_ready, 0);
    end
    step();
    chk("init.done.wr_en", wr_en, 0);
    chk("init.done.ready", in_ready, 1);

    // Back-to-back printables
    send(8'h41); chk_wr("A", 4'd0, 8'h41);
    send(8'h42); chk_wr("B", 4'd1, 8'h42);
    send(8'h43); chk_wr("C", 4'd2, 8'h43);
    chk("ABC.col", cur_col, 3);
    chk("ABC.ready", in_ready, 1);
    step();
    chk("idle.wr_en", wr_en, 0);

    send(8'h0D);
    chk("CR.wr_en", wr_en, 0);
    chk("CR.col", cur_col, 0);

    // Wrap without scroll
    send(8'h57); chk_wr("W", 4'd0, 8'h57);
    send(8'h58); chk_wr("X", 4'd1, 8'h58);
    send(8'h59); chk_wr("Y", 4'd2, 8'h59);
    send(8'h5A); chk_wr("Z", 4'd3, 8'h5A);
    chk("WXYZ.col", cur_col, 0);
    chk("WXYZ.row", cur_row, 1);
    chk("WXYZ.base", scroll_base, 0);
    chk("WXYZ.ready", in_ready, 1);

    send(8'h07);
    chk("ign.wr_en", wr_en, 0);
    chk("ign.col", cur_col, 0);
    chk("ign.row", cur_row, 1);

    // Backspace
    send(8'h51); chk_wr("Q", 4'd4, 8'h51);
    chk("Q.col", cur_col, 1);
    send(8'h08);
`ifdef TEXT_WRITER_BACKSPACE_EN
    chk_wr("BS", 4'd4, 8'h20);
    chk("BS.col", cur_col, 0);
`else
    chk("BS.wr_en", wr_en, 0);
    chk("BS.col", cur_col, 1);
`endif
    send(8'h0D);
    send(8'h08);
    chk("BS0.wr_en", wr_en, 0);
    chk("BS0.col", cur_col, 0);
    chk("BS0.row", cur_row, 1);

    // LF on the bottom row scrolls and clears physical row 0
    send(8'h0A);
    chk("LF.row", cur_row, 2);
    chk("LF.wr_en", wr_en, 0);
    send(8'h0A);
    chk_wr("scr.clr0", 4'd0, 8'h20);
    chk("scr.base", scroll_base, 1);
    chk("scr.row", cur_row, 2);
    chk("scr.col", cur_col, 0);
    chk("scr.ready0", in_ready, 0);
    for (int i = 1; i < COLS; i++) begin
      step();
      chk_wr("scr.clr", ADDR_W'(i), 8'h20);
      chk("scr.ready", in_ready, 0);
    end
    step();
    chk("scr.done.ready", in_ready, 1);
    chk("scr.done.wr_en", wr_en, 0);

    // Wrap on bottom row: char lands in old bottom (phys 0), then phys 1 is cleared
    send(8'h61); chk_wr("a", 4'd0, 8'h61);
    send(8'h62); chk_wr("b", 4'd1, 8'h62);
    send(8'h63); chk_wr("c", 4'd2, 8'h63);
    send(8'h64); chk_wr("d", 4'd3, 8'h64);
    chk("wrap.ready", in_ready, 0);
    chk("wrap.base", scroll_base, 2);
    chk("wrap.row", cur_row, 2);
    chk("wrap.col", cur_col, 0);
    for (int i = 0; i < COLS; i++) begin
      step();
      chk_wr("wrap.clr", ADDR_W'(4 + i), 8'h20);
      chk("wrap.clr.ready", in_ready, 0);
    end
    step();
    chk("wrap.done.ready", in_ready, 1);

    // Base wraps 2 -> 0; clear phys row 2
    send(8'h0A);
    chk_wr("lf2.clr0", 4'd8, 8'h20);
    chk("lf2.base", scroll_base, 0);
    for (int i = 1; i < COLS; i++) begin
      step();
      chk_wr("lf2.clr", ADDR_W'(8 + i), 8'h20);
    end
    step();
    chk("lf2.done.ready", in_ready, 1);

    // Reset mid-clear, with a byte presented during reset
    send(8'h0A);
    chk_wr("lf3.clr0", 4'd0, 8'h20);
    chk("lf3.base", scroll_base, 1);
    step();
    chk_wr("lf3.clr1", 4'd1, 8'h20);
    clr = 1'b1; in_ascii = 8'h58; in_valid = 1'b1;
    step();
    chk("mid.rst.wr_en", wr_en, 0);
    chk("mid.rst.base", scroll_base, 0);
    chk("mid.rst.row", cur_row, 0);
    chk("mid.rst.ready", in_ready, 0);
    clr = 1'b0; in_valid = 1'b0;
    step();
    chk_wr("reinit0", 4'd0, 8'h20);
    chk("reinit.ready", in_ready, 0);
    step();
    chk_wr("reinit1", 4'd1, 8'h20);
    chk("reinit.col", cur_col, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
